// File: rtl/gfx_pkg.sv
// Shared framebuffer definitions: geometry, merged-word layout, flush FSM states.
package gfx_pkg;

    localparam int unsigned FB_WIDTH  = 640;
    localparam int unsigned FB_HEIGHT = 480;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned LIN_W     = 19;

    // One SRAM word: four 4-bit lanes plus a per-lane write enable.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic [3:0]        mask;
    } fb_word_t;

    typedef enum logic [1:0] {
        StRun,
        StFlushPush,
        StFlushDrain
    } flush_st_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of merged framebuffer words; a push into a full FIFO is
// accepted when the head is popped on the same edge.
module fb_wr_fifo
    import gfx_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  fb_word_t din,
    input  logic     pop,
    output fb_word_t dout,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fb_word_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Status flags and qualified push/pop.
    always_comb begin
        full    = (count == (PTR_W+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr];
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_combiner.sv
// Merges 4-bit pixel writes into masked 16-bit SRAM word writes, buffers them in
// a FIFO and drains them under valid/ready; flush pushes the open word and waits
// for the memory side to go idle.
module fb_write_combiner #(
    parameter int unsigned FB_WIDTH   = 640,
    parameter int unsigned FB_HEIGHT  = 480,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [3:0]        pix_data,
    output logic              pix_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic              mem_ready,
    output logic              overflow,
    output logic [15:0]       oob_count
);

    import gfx_pkg::*;

    logic [LIN_W-1:0]  lin;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        lane;
    logic              oob;
    logic              accept;
    logic              accept_in;
    logic              new_word;
    logic              alive;
    logic              open_v;
    fb_word_t          open_word;
    fb_word_t          merged;
    fb_word_t          fifo_head;
    flush_st_e         state;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    // Address decode, merge of the incoming pixel, handshakes and output decode.
    always_comb begin
        lin       = LIN_W'(pix_y) * LIN_W'(FB_WIDTH) + LIN_W'(pix_x);
        word_addr = ADDR_W'(lin[LIN_W-1:2]);
        lane      = pix_x[1:0];
        oob       = (32'(pix_x) >= FB_WIDTH) || (32'(pix_y) >= FB_HEIGHT);

        // alive holds ready low for the first cycle out of reset
        pix_ready = alive && (state == StRun) && !fifo_full;
        accept    = pix_valid && pix_ready;
        accept_in = accept && !oob;
        new_word  = !open_v || (open_word.addr != word_addr);

        merged = open_word;
        if (new_word) begin
            merged.addr = word_addr;
            merged.data = '0;
            merged.mask = '0;
        end
        merged.data[{lane, 2'b00} +: 4] = pix_data;
        merged.mask[lane]               = 1'b1;

        mem_we    = !fifo_empty;
        mem_addr  = mem_we ? ADDR_W'(fifo_head.addr) : '0;
        mem_wdata = mem_we ? fifo_head.data : '0;
        mem_mask  = mem_we ? fifo_head.mask : '0;
        fifo_pop  = mem_we && mem_ready;

        // Evict on a word change, or flush out the open word once there is room.
        fifo_push = (accept_in && open_v && (open_word.addr != word_addr))
                  || ((state == StFlushPush) && open_v && (!fifo_full || fifo_pop));

        flush_done = (state == StFlushDrain) && fifo_empty;
    end

    // Open-word register, flush FSM, sticky overflow and out-of-range counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            alive     <= 1'b0;
            open_v    <= 1'b0;
            open_word <= '0;
            state     <= StRun;
            overflow  <= 1'b0;
            oob_count <= '0;
        end else begin
            alive <= 1'b1;
            if (pix_valid && !pix_ready) begin
                overflow <= 1'b1;
            end
            if (accept && oob && (oob_count != 16'hFFFF)) begin
                oob_count <= oob_count + 16'd1;
            end
            if (accept_in) begin
                open_v    <= 1'b1;
                open_word <= merged;
            end
            unique case (state)
                StRun: begin
                    if (flush) begin
                        state <= StFlushPush;
                    end
                end
                StFlushPush: begin
                    if (!open_v) begin
                        state <= StFlushDrain;
                    end else if (fifo_push) begin
                        open_v <= 1'b0;
                        state  <= StFlushDrain;
                    end
                end
                StFlushDrain: begin
                    if (fifo_empty) begin
                        state <= StRun;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (open_word),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fb_write_combiner.sv
// Bench for fb_write_combiner: behavioural word-merging model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fb_write_combiner;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [3:0]  pix_data = '0;
    logic        flush = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pix_ready;
    logic        flush_done;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        overflow;
    logic [15:0] oob_count;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 0;

    // model state
    wr_t m_q[$];
    wr_t obs_q[$];
    bit  m_open_v;
    wr_t m_open;
    int  m_phase;
    bit  m_alive;
    bit  m_ovf;
    int  m_oob;

    always #5 clk = ~clk;

    fb_write_combiner #(
        .FB_WIDTH   (640),
        .FB_HEIGHT  (480),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (17)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_ready  (mem_ready),
        .overflow   (overflow),
        .oob_count  (oob_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: queue of words owed to memory, one open word, flush phase.
    always @(posedge clk) begin : model
        int  sz0;
        int  px;
        int  py;
        int  lin;
        int  ln;
        bit  pop;
        bit  rdy;
        sz0 = m_q.size();
        if (reset) begin
            m_q.delete();
            m_open_v = 0;
            m_open   = '0;
            m_phase  = 0;
            m_alive  = 0;
            m_ovf    = 0;
            m_oob    = 0;
        end else begin
            pop = (sz0 > 0) && mem_ready;
            rdy = m_alive && (m_phase == 0) && (sz0 < DEPTH);
            if (pop) void'(m_q.pop_front());
            if (pix_valid && !rdy) begin
                m_ovf = 1;
            end else if (pix_valid) begin
                px = int'(pix_x);
                py = int'(pix_y);
                if (px >= 640 || py >= 480) begin
                    if (m_oob < 65535) m_oob++;
                end else begin
                    lin = py * 640 + px;
                    ln  = lin % 4;
                    if (m_open_v && (m_open.addr != 17'(lin / 4))) begin
                        m_q.push_back(m_open);
                        m_open_v = 0;
                    end
                    if (!m_open_v) begin
                        m_open.addr = 17'(lin / 4);
                        m_open.data = '0;
                        m_open.mask = '0;
                        m_open_v    = 1;
                    end
                    m_open.data[ln*4 +: 4] = pix_data;
                    m_open.mask[ln]        = 1'b1;
                end
            end
            if (m_phase == 0) begin
                if (flush) m_phase = 1;
            end else if (m_phase == 1) begin
                if (!m_open_v) begin
                    m_phase = 2;
                end else if (sz0 < DEPTH || pop) begin
                    m_q.push_back(m_open);
                    m_open_v = 0;
                    m_phase  = 2;
                end
            end else if (sz0 == 0) begin
                m_phase = 0;
            end
            m_alive = 1;
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit ew;
            ew = m_q.size() > 0;
            chk("mem_we", 32'(mem_we), 32'(ew));
            if (ew) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_q[0].addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_q[0].data));
                chk("mem_mask", 32'(mem_mask), 32'(m_q[0].mask));
            end
            chk("pix_ready", 32'(pix_ready),
                32'(m_alive && (m_phase == 0) && (m_q.size() < DEPTH)));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("oob_count", 32'(oob_count), 32'(m_oob));
            chk("flush_done", 32'(flush_done), 32'((m_phase == 2) && (m_q.size() == 0)));
            if (mem_we && mem_ready) begin
                obs_q.push_back('{addr: mem_addr, data: mem_wdata, mask: mem_mask});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input int d);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_data  = 4'(d);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic do_flush(input string name);
        bit got;
        got   = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (flush_done) begin
                got = 1;
                break;
            end
        end
        chk({name, "_flush_done_seen"}, 32'(got), 32'd1);
        tick();
    endtask

    task automatic chk_wr(input string name, input int idx, input int a, input int d,
                          input int m);
        wr_t w;
        w = (idx < obs_q.size()) ? obs_q[idx] : '0;
        chk({name, "_addr"}, 32'(w.addr), a);
        chk({name, "_wdata"}, 32'(w.data), d);
        chk({name, "_mask"}, 32'(w.mask), m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;
        tick();

        // 1: four lanes of one word merge into a single full-mask write
        obs_q.delete();
        pix(0, 0, 4'hF);
        pix(1, 0, 4'hA);
        pix(2, 0, 4'h5);
        pix(3, 0, 4'h1);
        do_flush("t1");
        chk("t1_count", 32'(obs_q.size()), 32'd1);
        chk_wr("t1_w0", 0, 0, 'h15AF, 'hF);

        // 2: different words are written in arrival order
        obs_q.delete();
        pix(4, 0, 4'hF);
        pix(0, 1, 4'hF);
        do_flush("t2");
        chk("t2_count", 32'(obs_q.size()), 32'd2);
        chk_wr("t2_w0", 0, 1, 'h000F, 'h1);
        chk_wr("t2_w1", 1, 160, 'h000F, 'h1);

        // 3: last write to a lane wins
        obs_q.delete();
        pix(5, 0, 4'h3);
        pix(5, 0, 4'hC);
        do_flush("t3");
        chk("t3_count", 32'(obs_q.size()), 32'd1);
        chk_wr("t3_w0", 0, 1, 'h00C0, 'h2);

        // 5: out-of-range pixels are counted and leave the open word alone
        obs_q.delete();
        pix(8, 2, 4'h7);
        pix(640, 0, 4'hF);
        pix(0, 480, 4'hF);
        @(negedge clk);
        chk("t5_oob_count", 32'(oob_count), 32'd2);
        chk("t5_no_write", 32'(obs_q.size()), 32'd0);
        tick();
        do_flush("t5");
        chk("t5_count", 32'(obs_q.size()), 32'd1);
        chk_wr("t5_w0", 0, 322, 'h0007, 'h1);

        // 4: back-pressure fills the FIFO, overflow, then gap-free drain
        obs_q.delete();
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) pix(4 * i, 0, 4'hF);
        @(negedge clk);
        chk("t4_ready_low", 32'(pix_ready), 32'd0);
        tick();
        pix(36, 0, 4'hF);
        @(negedge clk);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_held", 32'(obs_q.size()), 32'd0);
        tick();
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_no_gap", 32'(mem_we), 32'd1);
        end
        @(negedge clk);
        chk("t4_drained", 32'(mem_we), 32'd0);
        tick();
        chk("t4_count8", 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_wr("t4_w", i, i, 'h000F, 'h1);
        do_flush("t4");
        chk("t4_count9", 32'(obs_q.size()), 32'd9);
        chk_wr("t4_w8", 8, 8, 'h000F, 'h1);

        // 6: reset while a write is stalled, then an empty flush
        mem_ready = 1'b0;
        pix(0, 0, 4'h1);
        pix(4, 0, 4'h2);
        @(negedge clk);
        chk("t6_stalled_we", 32'(mem_we), 32'd1);
        chk("t6_ovf_before", 32'(overflow), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_we", 32'(mem_we), 32'd0);
        chk("t6_rst_ready", 32'(pix_ready), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        chk("t6_rst_oob", 32'(oob_count), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_ready_back", 32'(pix_ready), 32'd1);
        tick();
        mem_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t6_fd_cycle1", 32'(flush_done), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_fd_cycle2", 32'(flush_done), 32'd1);
        tick();
        @(negedge clk);
        chk("t6_fd_pulse", 32'(flush_done), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
